wbc_rr_intercon: RTL
====================

WBC_RR_INTERCON -- requirements
Module: wbc_rr_intercon

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 4, number of WISHBONE master ports (2..8).
REQ-002 SHALL provide parameter NUM_SLAVES, default 4, number of slave ports (power of 2, 2..8).
REQ-003 SHALL provide parameter ADDR_WIDTH, default 20, control-bus address width.
REQ-004 SHALL provide parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-005 SHALL provide parameter TIMEOUT_CYCLES, default 255, stalled-strobe cycles before a forced err (1..65535).
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports m_cyc_i, m_stb_i, m_we_i, input, NUM_MASTERS each, per-master cycle, strobe and write-enable.
REQ-009 SHALL have ports m_adr_i, m_dat_i, m_sel_i, input, NUM_MASTERS*ADDR_WIDTH, NUM_MASTERS*DATA_WIDTH and NUM_MASTERS*DATA_WIDTH/8, flattened with master k at slice k.
REQ-010 SHALL have ports m_ack_o, m_err_o, m_rty_o, output, NUM_MASTERS each, per-master termination.
REQ-011 SHALL have port m_dat_o, output, DATA_WIDTH, read data shared by all masters.
REQ-012 SHALL have ports s_cyc_o, s_stb_o, output, NUM_SLAVES each, per-slave cycle and strobe.
REQ-013 SHALL have ports s_we_o, s_adr_o, s_dat_o, s_sel_o, output, 1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8, shared slave bus.
REQ-014 SHALL have ports s_dat_i (NUM_SLAVES*DATA_WIDTH), s_ack_i, s_err_i, s_rty_i (NUM_SLAVES each), input, slave responses.
REQ-015 SHALL have ports grant_o (output, NUM_MASTERS, one-hot current owner), timeout_o (output, 1, one-cycle pulse) and debug_o (output, 71, debug bus).

Function
REQ-016 SHALL run a two-state FSM: IDLE, BUSY.
REQ-017 In IDLE, SHALL select the first master with m_cyc_i high, searching round-robin from last_grant+1 modulo NUM_MASTERS; grant_o is registered and goes high on the next edge (one-cycle arbitration latency), FSM -> BUSY.
REQ-018 In BUSY, SHALL hold the grant while the owner's m_cyc_i is high; no preemption.
REQ-019 When the owner drops m_cyc_i, SHALL clear grant_o, update last_grant and return to IDLE on the next edge; one dead cycle between owners always occurs, even with other requests pending.
REQ-020 SHALL decode the slave index from s_adr_o[ADDR_WIDTH-1 -: log2(NUM_SLAVES)]; only the decoded slave sees s_cyc_o/s_stb_o, combinationally from the owner.
REQ-021 SHALL route the decoded slave's ack/err/rty and s_dat_i combinationally to the owner only; non-owners see all terminations low.
REQ-022 SHALL keep a stall counter that clears when s_stb_o is low or any termination occurs, and increments otherwise.
REQ-023 When the counter reaches TIMEOUT_CYCLES, SHALL assert m_err_o of the owner and timeout_o for exactly one cycle, force s_stb_o low that cycle, and clear the counter.
REQ-024 A slave termination arriving in the same cycle as the timeout SHALL take priority; no timeout is raised.
REQ-025 m_dat_o SHALL be zero whenever no termination is being presented.
REQ-026 debug_o SHALL carry {grant index (3), state (1), stall counter low 16 bits, s_adr_o low 20 bits, m_dat_o low 31 bits}, registered.

Reset
REQ-027 On rst_i high, SHALL immediately force FSM=IDLE, grant_o=0, s_cyc_o=s_stb_o=0, all terminations 0, timeout_o=0, counter=0, debug_o=0, last_grant=NUM_MASTERS-1 (master 0 wins first).
REQ-028 Reset asserted mid-transfer SHALL abort the transfer without any termination to the master.

Structure
REQ-029 SHALL place the FSM state encoding and the debug_o field offsets in the shared WISHBONE package/header.
REQ-030 SHALL implement the round-robin selector as sub-module wbc_rr_arbiter (request vector, last grant in; one-hot grant out).

Verification
REQ-031 Masters 0 and 2 raise cyc in the same cycle after reset -> master 0 granted at the next edge; after master 0 releases, one dead cycle, then master 2 granted.
REQ-032 Master 1 reads address 0x40010 (4 slaves, 20 bits) -> only s_cyc_o[1] asserted; slave 1 acks with 0xDEADBEEF -> m_ack_o[1]=1 and m_dat_o=0xDEADBEEF in the same cycle.
REQ-033 TIMEOUT_CYCLES=8, slave never acks -> m_err_o[owner] and timeout_o high for one cycle, 8 strobed cycles after grant; s_stb_o low in that cycle.
REQ-034 Slave acks in the cycle the counter reaches the limit -> ack delivered, timeout_o stays low.
REQ-035 All four masters continuously request -> grants rotate 0,1,2,3,0 with one dead cycle between owners.
REQ-036 rst_i pulsed during a BUSY write -> all outputs zero asynchronously; after release, master 0 wins first arbitration.

Source files
------------

// File: rtl/wbc_rr_intercon_pkg.sv
// Shared types for the round-robin WISHBONE interconnect:
// FSM state encoding, debug bus layout and the stall counter width.
package wbc_rr_intercon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int CNT_W = 16;

  localparam int DBG_W       = 71;
  localparam int DBG_DAT_LSB = 0;
  localparam int DBG_DAT_W   = 31;
  localparam int DBG_ADR_LSB = 31;
  localparam int DBG_ADR_W   = 20;
  localparam int DBG_CNT_LSB = 51;
  localparam int DBG_CNT_W   = 16;
  localparam int DBG_ST_LSB  = 67;
  localparam int DBG_GNT_LSB = 68;
  localparam int DBG_GNT_W   = 3;

endpackage

// File: rtl/wbc_rr_intercon_if.sv
// Bus bundle: N master ports in, M slave ports out, flattened per port.
// slave = interconnect side, master = bus agents driving requests/responses.
interface wbc_rr_intercon_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32
);
  import wbc_rr_intercon_pkg::*;

  localparam int SELW = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SELW-1:0]       m_sel_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [NUM_MASTERS-1:0]            m_rty_o;
  logic [DATA_WIDTH-1:0]             m_dat_o;

  logic [NUM_SLAVES-1:0]             s_cyc_o;
  logic [NUM_SLAVES-1:0]             s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SELW-1:0]                   s_sel_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_i;
  logic [NUM_SLAVES-1:0]             s_ack_i;
  logic [NUM_SLAVES-1:0]             s_err_i;
  logic [NUM_SLAVES-1:0]             s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_adr_i, m_dat_i, m_sel_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i,
    output m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/wbc_rr_intercon_arbiter.sv
// Round-robin selector: req vector + last grant index in, one-hot gnt out.
// Search starts at last+1 and wraps; gnt is zero when nobody requests.
module wbc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbc_rr_intercon.sv
// Round-robin WISHBONE interconnect: N masters share one slave bus, address-decoded
// to M slaves, with stall timeout. Ports: clk_i, rst_i, bus, grant_o, timeout_o, debug_o.
module wbc_rr_intercon
  import wbc_rr_intercon_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wbc_rr_intercon_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o,
  output logic [DBG_W-1:0]       debug_o
);

  localparam int MW   = $clog2(NUM_MASTERS);
  localparam int SW   = $clog2(NUM_SLAVES);
  localparam int SELW = DATA_WIDTH / 8;
  localparam int AWD  = ADDR_WIDTH < DBG_ADR_W ? ADDR_WIDTH : DBG_ADR_W;
  localparam int DWD  = DATA_WIDTH < DBG_DAT_W ? DATA_WIDTH : DBG_DAT_W;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MW-1:0]          last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_MASTERS-1:0] arb_gnt;

  logic [MW-1:0]          own_idx;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic [SELW-1:0]        own_sel;

  logic [SW-1:0]          sidx;
  logic                   slv_ack;
  logic                   slv_err;
  logic                   slv_rty;
  logic                   slv_term;
  logic [DATA_WIDTH-1:0]  slv_dat;
  logic                   tmo;
  logic                   stb_now;
  logic [DATA_WIDTH-1:0]  m_dat;

  logic [DBG_GNT_W-1:0]   dbg_gnt;
  logic [DBG_ADR_W-1:0]   dbg_adr;
  logic [DBG_DAT_W-1:0]   dbg_dat;
  logic [DBG_W-1:0]       dbg_d;

  wbc_rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_arb (
    .req  (bus.m_cyc_i),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // grant_q is one-hot or zero, so a plain overwrite loop is a clean mux
  always_comb begin
    own_idx = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        own_idx = MW'(k);
        own_cyc = bus.m_cyc_i[k];
        own_stb = bus.m_stb_i[k];
        own_we  = bus.m_we_i[k];
        own_adr = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_dat = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        own_sel = bus.m_sel_i[k*SELW +: SELW];
      end
    end
  end

  assign sidx = own_adr[ADDR_WIDTH-1 -: SW];

  always_comb begin
    slv_dat = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (sidx == SW'(s)) begin
        slv_dat = bus.s_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign slv_ack  = own_cyc & bus.s_ack_i[sidx];
  assign slv_err  = own_cyc & bus.s_err_i[sidx];
  assign slv_rty  = own_cyc & bus.s_rty_i[sidx];
  assign slv_term = slv_ack | slv_err | slv_rty;

  // a real slave response in the limit cycle beats the timeout
  assign tmo     = own_cyc & own_stb & (cnt_q == TMO) & ~slv_term;
  assign stb_now = own_cyc & own_stb & ~tmo;
  assign m_dat   = slv_term ? slv_dat : '0;

  always_comb begin
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    bus.s_cyc_o[sidx] = own_cyc;
    bus.s_stb_o[sidx] = stb_now;
  end

  assign bus.s_we_o  = own_we;
  assign bus.s_adr_o = own_adr;
  assign bus.s_dat_o = own_dat;
  assign bus.s_sel_o = own_sel;

  assign bus.m_ack_o = grant_q & {NUM_MASTERS{slv_ack}};
  assign bus.m_err_o = grant_q & {NUM_MASTERS{slv_err | tmo}};
  assign bus.m_rty_o = grant_q & {NUM_MASTERS{slv_rty}};
  assign bus.m_dat_o = m_dat;

  assign grant_o   = grant_q;
  assign timeout_o = tmo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.m_cyc_i) begin
            grant_q <= arb_gnt;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            grant_q <= '0;
            last_q  <= own_idx;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!stb_now || slv_term) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    dbg_gnt = '0;
    dbg_adr = '0;
    dbg_dat = '0;
    dbg_gnt[MW-1:0]  = own_idx;
    dbg_adr[AWD-1:0] = own_adr[AWD-1:0];
    dbg_dat[DWD-1:0] = m_dat[DWD-1:0];
    dbg_d = '0;
    dbg_d[DBG_GNT_LSB +: DBG_GNT_W] = dbg_gnt;
    dbg_d[DBG_ST_LSB]               = state_q;
    dbg_d[DBG_CNT_LSB +: DBG_CNT_W] = cnt_q;
    dbg_d[DBG_ADR_LSB +: DBG_ADR_W] = dbg_adr;
    dbg_d[DBG_DAT_LSB +: DBG_DAT_W] = dbg_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      debug_o <= '0;
    end else begin
      debug_o <= dbg_d;
    end
  end

endmodule
